// File: rtl/adc_pk_pkg.sv
// ---------------------------------------------------------------------------
// adc_pk_pkg
//   Shared types for the ADC frame packer:
//     state_t    - byte-emission FSM states
//     sample_t   - one buffered sample {otr, data[11:0]}
//     FLG_*      - bit positions inside the header flags byte
//     flags_byte - assembles the header flags byte from the sticky flags
// ---------------------------------------------------------------------------
package adc_pk_pkg;

  localparam int SMP_W    = 12;
  localparam int FLG_OTR  = 0;
  localparam int FLG_DROP = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    H0   = 3'd1,
    H1   = 3'd2,
    H2   = 3'd3,
    H3   = 3'd4,
    P0   = 3'd5,
    P1   = 3'd6,
    P2   = 3'd7
  } state_t;

  typedef struct packed {
    logic             otr;
    logic [SMP_W-1:0] data;
  } sample_t;

  function automatic logic [7:0] flags_byte(input logic drop_flag, input logic otr_flag);
    logic [7:0] b;
    b = 8'h00;
    b[FLG_DROP] = drop_flag;
    b[FLG_OTR]  = otr_flag;
    return b;
  endfunction

endpackage

// File: rtl/adc_pk_sbuf.sv
// ---------------------------------------------------------------------------
// adc_pk_sbuf
//   Small synchronous sample FIFO between the ADC capture stage and the
//   byte-emission FSM. Read data is first-word-fall-through: pop_data shows
//   the oldest entry whenever empty=0, so the FSM can emit a byte from it in
//   the same cycle it pops.
//
// Ports:
//   clk        in   clock
//   srst       in   synchronous active-high reset, empties the buffer
//   push       in   push request (already qualified by enable/strobe)
//   push_data  in   entry to store
//   pop        in   pop request
//   pop_data   out  oldest entry (valid when empty=0)
//   full       out  buffer holds DEPTH entries
//   empty      out  buffer holds no entries
//   drop       out  push request rejected because the buffer stayed full
// ---------------------------------------------------------------------------
module adc_pk_sbuf
  import adc_pk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    srst,
  input  logic    push,
  input  sample_t push_data,
  input  logic    pop,
  output sample_t pop_data,
  output logic    full,
  output logic    empty,
  output logic    drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  sample_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // A pop in the same cycle frees a slot, so a push into a full buffer is
  // still accepted when the FSM is draining it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  assign pop_data = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// ---------------------------------------------------------------------------
// adc_frame_packer
//   Packs 12-bit ADC samples into a byte stream for the async USB FIFO.
//   Each frame: SYNC0, SYNC1, sequence number, flags byte, then sample pairs
//   packed as 3 bytes {A[11:4]}, {A[3:0],B[11:8]}, {B[7:0]}.
//   The flags byte reports drops and out-of-range samples seen since the
//   previous header, so it describes the previous frame.
//
// Ports:
//   clk_i         in   adc_clk
//   rst_i         in   synchronous active-high reset
//   en_i          in   capture enable (gates pushes and frame starts)
//   smp_valid_i   in   sample strobe, at most one per 2 clocks
//   smp_data_i    in   12-bit sample, offset binary
//   smp_otr_i     in   out-of-range flag, qualified by smp_valid_i
//   fifo_full_i   in   async FIFO write-side full
//   fifo_data_o   out  byte to FIFO (zero when not writing)
//   fifo_wrreq_o  out  FIFO write strobe
//   busy_o        out  FSM not in IDLE
//   frame_seq_o   out  sequence number of the last emitted header
//   drop_cnt_o    out  saturating count of samples lost to overflow
// ---------------------------------------------------------------------------
module adc_frame_packer
  import adc_pk_pkg::*;
#(
  parameter int         SAMPLES_PER_FRAME = 256,
  parameter logic [7:0] SYNC0             = 8'hA5,
  parameter logic [7:0] SYNC1             = 8'h5A,
  parameter int         SBUF_DEPTH        = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              smp_valid_i,
  input  logic [SMP_W-1:0]  smp_data_i,
  input  logic              smp_otr_i,
  input  logic              fifo_full_i,
  output logic [7:0]        fifo_data_o,
  output logic              fifo_wrreq_o,
  output logic              busy_o,
  output logic [7:0]        frame_seq_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int PAIRS = SAMPLES_PER_FRAME / 2;
  // +1 keeps the counter at least one bit wide for a single-pair frame.
  localparam int PCW = $clog2(PAIRS + 1);
  localparam logic [PCW-1:0] LAST_PAIR = PCW'(PAIRS - 1);

  state_t         state_reg;
  state_t         state_next;
  logic [PCW-1:0] pair_cnt_reg;
  logic [PCW-1:0] pair_cnt_next;
  logic [3:0]     a_low_reg;
  logic [7:0]     b_low_reg;
  logic [7:0]     frame_seq_reg;
  logic [15:0]    drop_cnt_reg;
  logic [15:0]    drop_cnt_next;
  logic           otr_flag_reg;
  logic           otr_flag_next;
  logic           drop_flag_reg;
  logic           drop_flag_next;

  logic           byte_avail;
  logic [7:0]     byte_mux;
  logic           wrreq;
  logic           pop;
  logic           flag_clear;

  sample_t        push_data;
  sample_t        pop_data;
  logic           sbuf_full;
  logic           sbuf_empty;
  logic           sbuf_drop;
  logic           push_req;

  // -------------------------------------------------------------------------
  // Sample buffer
  // -------------------------------------------------------------------------
  assign push_req       = en_i && smp_valid_i;
  assign push_data.otr  = smp_otr_i;
  assign push_data.data = smp_data_i;

  adc_pk_sbuf #(
    .DEPTH (SBUF_DEPTH)
  ) u_sbuf (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (sbuf_full),
    .empty     (sbuf_empty),
    .drop      (sbuf_drop)
  );

  // -------------------------------------------------------------------------
  // FSM: byte mux, write strobe and next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pair_cnt_next = pair_cnt_reg;
    byte_avail    = 1'b0;
    byte_mux      = 8'h00;

    case (state_reg)
      H0: begin
        byte_avail = 1'b1;
        byte_mux   = SYNC0;
      end
      H1: begin
        byte_avail = 1'b1;
        byte_mux   = SYNC1;
      end
      H2: begin
        byte_avail = 1'b1;
        byte_mux   = frame_seq_reg + 8'd1;
      end
      H3: begin
        byte_avail = 1'b1;
        byte_mux   = flags_byte(drop_flag_reg, otr_flag_reg);
      end
      P0: begin
        byte_avail = !sbuf_empty;
        byte_mux   = pop_data.data[11:4];
      end
      P1: begin
        byte_avail = !sbuf_empty;
        byte_mux   = {a_low_reg, pop_data.data[11:8]};
      end
      P2: begin
        byte_avail = 1'b1;
        byte_mux   = b_low_reg;
      end
      default: begin
        byte_avail = 1'b0;
      end
    endcase

    // Reset forces the strobe low in the cycle it is asserted, so a frame
    // cut short by reset never gets another byte.
    wrreq = byte_avail && !fifo_full_i && !rst_i;
    pop   = wrreq && ((state_reg == P0) || (state_reg == P1));

    case (state_reg)
      IDLE: if (en_i && !sbuf_empty) state_next = H0;
      H0:   if (wrreq) state_next = H1;
      H1:   if (wrreq) state_next = H2;
      H2:   if (wrreq) state_next = H3;
      H3:   if (wrreq) state_next = P0;
      P0:   if (wrreq) state_next = P1;
      P1:   if (wrreq) state_next = P2;
      P2: begin
        if (wrreq) begin
          if (pair_cnt_reg == LAST_PAIR) begin
            pair_cnt_next = '0;
            state_next    = (en_i && !sbuf_empty) ? H0 : IDLE;
          end else begin
            pair_cnt_next = pair_cnt_reg + 1'b1;
            state_next    = P0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sticky flags and drop counter
  // -------------------------------------------------------------------------
  always_comb begin
    // The flags byte write clears both flags; an event in that same cycle
    // belongs to the next frame and re-sets it.
    flag_clear     = wrreq && (state_reg == H3);
    otr_flag_next  = (otr_flag_reg && !flag_clear) || (pop && pop_data.otr);
    drop_flag_next = (drop_flag_reg && !flag_clear) || sbuf_drop;

    drop_cnt_next = drop_cnt_reg;
    if (sbuf_drop && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_next = drop_cnt_reg + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      pair_cnt_reg  <= '0;
      a_low_reg     <= 4'h0;
      b_low_reg     <= 8'h00;
      frame_seq_reg <= 8'h00;
      drop_cnt_reg  <= 16'h0000;
      otr_flag_reg  <= 1'b0;
      drop_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pair_cnt_reg  <= pair_cnt_next;
      drop_cnt_reg  <= drop_cnt_next;
      otr_flag_reg  <= otr_flag_next;
      drop_flag_reg <= drop_flag_next;

      // Keep the parts of A and B not yet emitted for the following bytes.
      if (pop && (state_reg == P0)) begin
        a_low_reg <= pop_data.data[3:0];
      end
      if (pop && (state_reg == P1)) begin
        b_low_reg <= pop_data.data[7:0];
      end
      if (wrreq && (state_reg == H2)) begin
        frame_seq_reg <= frame_seq_reg + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign fifo_wrreq_o = wrreq;
  assign fifo_data_o  = wrreq ? byte_mux : 8'h00;
  assign busy_o       = (state_reg != IDLE);
  assign frame_seq_o  = frame_seq_reg;
  assign drop_cnt_o   = drop_cnt_reg;

endmodule

// File: tb/tb_adc_frame_packer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_adc_frame_packer
//   Scoreboard bench: every sample the bench expects to be accepted is fed to
//   a byte-stream model that appends the resulting header/payload bytes to
//   exp_q; a monitor pops exp_q on every FIFO write and compares.
// ---------------------------------------------------------------------------
module tb_adc_frame_packer;

  localparam int SPF   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        smp_valid;
  logic [11:0] smp_data;
  logic        smp_otr;
  logic        fifo_full;
  logic [7:0]  fifo_data;
  logic        fifo_wrreq;
  logic        busy;
  logic [7:0]  frame_seq;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  adc_frame_packer #(
    .SAMPLES_PER_FRAME (SPF),
    .SYNC0             (8'hA5),
    .SYNC1             (8'h5A),
    .SBUF_DEPTH        (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .smp_valid_i  (smp_valid),
    .smp_data_i   (smp_data),
    .smp_otr_i    (smp_otr),
    .fifo_full_i  (fifo_full),
    .fifo_data_o  (fifo_data),
    .fifo_wrreq_o (fifo_wrreq),
    .busy_o       (busy),
    .frame_seq_o  (frame_seq),
    .drop_cnt_o   (drop_cnt)
  );

  int         checks = 0;
  int         errors = 0;
  int         bytes_seen = 0;
  logic [7:0] exp_q[$];

  // Byte-stream model state
  int          m_pos = 0;
  logic [7:0]  m_seq = 8'h00;
  logic        m_otr_acc = 1'b0;
  logic        m_drop_pend = 1'b0;
  logic [11:0] m_a = 12'h000;
  bit          bp_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A sample accepted by the packer turns into bytes purely by position in
  // the stream: a header before every SPF-th sample, 1 byte for the first of
  // a pair, 2 bytes for the second.
  task model_accept(input logic [11:0] d, input logic otr);
    if (m_pos == 0) begin
      m_seq = m_seq + 8'd1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(m_seq);
      exp_q.push_back({6'b0, m_drop_pend, m_otr_acc});
      m_drop_pend = 1'b0;
      m_otr_acc   = 1'b0;
    end
    m_otr_acc = m_otr_acc | otr;
    if ((m_pos % 2) == 0) begin
      exp_q.push_back(d[11:4]);
      m_a = d;
    end else begin
      exp_q.push_back({m_a[3:0], d[11:8]});
      exp_q.push_back(d[7:0]);
    end
    m_pos = (m_pos + 1) % SPF;
  endtask

  task model_reset();
    exp_q.delete();
    m_pos       = 0;
    m_seq       = 8'h00;
    m_otr_acc   = 1'b0;
    m_drop_pend = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task send_sample(input logic [11:0] d, input logic otr, input bit accept, input int gap);
    smp_data  = d;
    smp_otr   = otr;
    smp_valid = 1'b1;
    if (accept) model_accept(d, otr);
    @(posedge clk); #1;
    smp_valid = 1'b0;
    smp_otr   = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task wait_bytes(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (bytes_seen < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bytes_seen < target) begin
      errors++;
      $display("FAIL %s_wait: bytes seen %0d, expected %0d", name, bytes_seen, target);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    if (fifo_wrreq === 1'b1) begin
      checks++;
      if (fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL wrreq_while_full: wrreq=1 with fifo_full=%b, required fifo_full=0", fifo_full);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, no byte expected", fifo_data);
      end else begin
        e = exp_q.pop_front();
        if (fifo_data !== e) begin
          errors++;
          $display("FAIL byte_%0d: got %02h, expected %02h", bytes_seen, fifo_data, e);
        end else begin
          $display("byte %0d: %02h", bytes_seen, fifo_data);
        end
      end
      bytes_seen++;
    end
  end

  // Random backpressure during the randomized phase
  always @(posedge clk) begin
    if (bp_random) begin
      #1;
      fifo_full = ($urandom_range(0, 7) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [11:0] r;

    rst = 1'b1; en = 1'b0; smp_valid = 1'b0; smp_data = 12'h000;
    smp_otr = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wrreq", fifo_wrreq, 0);
    check("reset_data", fifo_data, 0);
    check("reset_busy", busy, 0);
    check("reset_seq", frame_seq, 0);
    check("reset_drop", drop_cnt, 0);
    rst = 1'b0;
    en  = 1'b1;

    // Framing
    send_sample(12'h123, 1'b0, 1'b1, 2);
    send_sample(12'h456, 1'b0, 1'b1, 2);
    send_sample(12'h789, 1'b0, 1'b1, 2);
    send_sample(12'hABC, 1'b0, 1'b1, 2);
    drain("framing", 100);
    check("framing_seq", frame_seq, 1);
    check("framing_drop", drop_cnt, 0);
    check("framing_idle", busy, 0);

    // Backpressure during P1
    base = bytes_seen;
    fork
      begin
        send_sample(12'h123, 1'b0, 1'b1, 2);
        send_sample(12'h456, 1'b0, 1'b1, 2);
        send_sample(12'h789, 1'b0, 1'b1, 2);
        send_sample(12'hABC, 1'b0, 1'b1, 2);
      end
      begin
        wait_bytes("bp", base + 5, 200);
        fifo_full = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          check("bp_stall_wrreq", fifo_wrreq, 0);
        end
        fifo_full = 1'b0;
      end
    join
    drain("bp", 100);
    check("bp_byte_count", bytes_seen - base, 10);

    // Overflow: FIFO held full while 12 samples arrive
    fifo_full   = 1'b1;
    m_drop_pend = 1'b1;
    for (int i = 0; i < 12; i++) begin
      r = 12'($urandom);
      send_sample(r, 1'b0, (i < DEPTH), 2);
    end
    check("ovf_drop_cnt", drop_cnt, 4);
    check("ovf_busy", busy, 1);
    fifo_full = 1'b0;
    drain("ovf", 200);
    check("ovf_drop_cnt_after", drop_cnt, 4);

    // OTR flag: flagged sample in frame 1 shows in frame 2's header only
    for (int i = 0; i < 3 * SPF; i++) begin
      r = 12'($urandom);
      send_sample(r, (i == 1), 1'b1, 3);
    end
    drain("otr", 200);

    // Enable dropped mid-frame; ignored strobes, then remainder supplied
    base = bytes_seen;
    send_sample(12'h3C5, 1'b0, 1'b1, 2);
    send_sample(12'hA0F, 1'b0, 1'b1, 2);
    en = 1'b0;
    send_sample(12'hFFF, 1'b0, 1'b0, 2);
    send_sample(12'h001, 1'b1, 1'b0, 2);
    repeat (16) @(posedge clk);
    #1;
    check("en_partial_bytes", bytes_seen - base, 7);
    check("en_stalled_busy", busy, 1);
    en = 1'b1;
    send_sample(12'h5A5, 1'b0, 1'b1, 2);
    send_sample(12'h0F0, 1'b0, 1'b1, 2);
    drain("en", 100);
    check("en_frame_bytes", bytes_seen - base, 10);
    check("en_idle", busy, 0);

    // Reset during P1
    base = bytes_seen;
    send_sample(12'h111, 1'b0, 1'b1, 2);
    send_sample(12'h222, 1'b0, 1'b1, 2);
    wait_bytes("rst", base + 5, 200);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_same_cycle_wrreq", fifo_wrreq, 0);
    check("rst_same_cycle_data", fifo_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_idle", busy, 0);
    check("rst_seq", frame_seq, 0);
    check("rst_drop", drop_cnt, 0);
    send_sample(12'h135, 1'b0, 1'b1, 2);
    send_sample(12'h7E9, 1'b0, 1'b1, 2);
    send_sample(12'hBDF, 1'b0, 1'b1, 2);
    send_sample(12'h246, 1'b0, 1'b1, 2);
    drain("post_rst", 100);
    check("post_rst_seq", frame_seq, 1);

    // Randomized run long enough to wrap the sequence number
    bp_random = 1'b1;
    for (int i = 0; i < 260 * SPF; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        r  = 12'($urandom);
        send_sample(r, 1'b1, 1'b0, 2);
        en = 1'b1;
      end
      r = 12'($urandom);
      send_sample(r, ($urandom_range(0, 7) == 0), 1'b1, $urandom_range(4, 7));
    end
    bp_random = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fifo_full = 1'b0;
    drain("random", 2000);
    check("random_seq_wrap", frame_seq, m_seq);
    check("random_drop", drop_cnt, 0);
    check("random_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
